// File: rtl/ieee2fpir_pipe_pkg.sv
// Shared FPIR definitions: type encodings, input classes and field-width helpers.
package ieee2fpir_pipe_pkg;

  localparam int BW_FPIR_TYPE = 3;
  localparam int BW_CLS       = 3;

  typedef enum logic [BW_FPIR_TYPE-1:0] {
    FT_NORMAL = 3'd0,
    FT_NAN    = 3'd1,
    FT_PZERO  = 3'd2,
    FT_MZERO  = 3'd3,
    FT_PINF   = 3'd4,
    FT_MINF   = 3'd5
  } fpir_type_e;

  typedef enum logic [BW_CLS-1:0] {
    CLS_NORMAL = 3'd0,
    CLS_SUB    = 3'd1,
    CLS_ZERO   = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } ieee_class_e;

  function automatic int ieee_width(int bw_exp, int bw_man);
    return 1 + bw_exp + bw_man;
  endfunction

  function automatic int fpir_width(int bw_exp, int bw_sig);
    return BW_FPIR_TYPE + 1 + bw_exp + bw_sig;
  endfunction

endpackage

// File: rtl/ieee2fpir_lane.sv
// One lane of IEEE->FPIR conversion, combinational. The classify/lzc half feeds
// the stage-1 registers; the normalise half works from those registers.
module ieee2fpir_lane
  import ieee2fpir_pipe_pkg::*;
#(
  parameter int BW_IEEE_EXPONENT    = 8,
  parameter int BW_IEEE_MANTISSA    = 23,
  parameter int BW_FPIR_EXPONENT    = BW_IEEE_EXPONENT + 2,
  parameter int BW_FPIR_SIGNIFICAND = BW_IEEE_MANTISSA + 1,
  parameter int BW_LZC              = $clog2(BW_IEEE_MANTISSA + 1)
) (
  input  logic [BW_IEEE_EXPONENT+BW_IEEE_MANTISSA:0]                      ieee_i,
  output logic [BW_CLS-1:0]                                               cls_o,
  output logic                                                            sign_o,
  output logic [BW_IEEE_EXPONENT-1:0]                                     exp_o,
  output logic [BW_IEEE_MANTISSA-1:0]                                     man_o,
  output logic [BW_LZC-1:0]                                               lzc_o,
  input  logic [BW_CLS-1:0]                                               cls_i,
  input  logic                                                            sign_i,
  input  logic [BW_IEEE_EXPONENT-1:0]                                     exp_i,
  input  logic [BW_IEEE_MANTISSA-1:0]                                     man_i,
  input  logic [BW_LZC-1:0]                                               lzc_i,
  input  logic                                                            ftz_i,
  output logic [BW_FPIR_TYPE+BW_FPIR_EXPONENT+BW_FPIR_SIGNIFICAND:0]      fpir_o
);
  localparam int E   = BW_IEEE_EXPONENT;
  localparam int M   = BW_IEEE_MANTISSA;
  localparam int FE  = BW_FPIR_EXPONENT;
  localparam int FS  = BW_FPIR_SIGNIFICAND;
  localparam int PAD = FS - M - 1;
  localparam logic [FE-1:0] BIAS = FE'(2**(E-1) - 1);

  assign sign_o = ieee_i[E+M];
  assign exp_o  = ieee_i[M +: E];
  assign man_o  = ieee_i[M-1:0];

  always_comb begin
    cls_o = CLS_NORMAL;
    if (&exp_o)             cls_o = (|man_o) ? CLS_NAN : CLS_INF;
    else if (exp_o == '0)   cls_o = (|man_o) ? CLS_SUB : CLS_ZERO;
  end

  // Ascending scan, last hit wins: ends on the most significant set bit.
  always_comb begin
    lzc_o = '0;
    for (int i = 0; i < M; i++)
      if (man_o[i]) lzc_o = BW_LZC'(M - 1 - i);
  end

  logic [M-1:0]  man_sh;
  logic [M:0]    sig_norm, sig_sub;
  logic [FE-1:0] exp_norm, exp_sub;
  fpir_type_e    typ;
  logic [FE-1:0] fexp;
  logic [FS-1:0] sig;

  // Shifting by lzc puts the leading one at the MSB, where it becomes the explicit bit.
  assign man_sh   = man_i << lzc_i;
  assign sig_sub  = {man_sh, 1'b0};
  assign sig_norm = {1'b1, man_i};
  assign exp_norm = FE'(exp_i) - BIAS;
  assign exp_sub  = FE'(0) - BIAS - FE'(lzc_i);

  always_comb begin
    typ  = FT_NORMAL;
    fexp = '0;
    sig  = '0;
    case (cls_i)
      CLS_NORMAL: begin
        fexp = exp_norm;
        sig  = FS'(sig_norm) << PAD;
      end
      CLS_SUB: begin
        if (ftz_i) typ = sign_i ? FT_MZERO : FT_PZERO;
        else begin
          fexp = exp_sub;
          sig  = FS'(sig_sub) << PAD;
        end
      end
      CLS_ZERO: typ = sign_i ? FT_MZERO : FT_PZERO;
      CLS_INF:  typ = sign_i ? FT_MINF  : FT_PINF;
      default:  typ = FT_NAN;
    endcase
  end

  assign fpir_o = {typ, sign_i, fexp, sig};

endmodule

// File: rtl/ieee2fpir_pipe.sv
// Two-stage, NUM_LANE-wide IEEE->FPIR converter with valid/ready on both sides
// and sticky NaN/subnormal status flags.
module ieee2fpir_pipe
  import ieee2fpir_pipe_pkg::*;
#(
  parameter int NUM_LANE            = 4,
  parameter int BW_IEEE_EXPONENT    = 8,
  parameter int BW_IEEE_MANTISSA    = 23,
  parameter int BW_FPIR_EXPONENT    = BW_IEEE_EXPONENT + 2,
  parameter int BW_FPIR_SIGNIFICAND = BW_IEEE_MANTISSA + 1
) (
  input  logic clk,
  input  logic rstnn,
  input  logic enable,
  input  logic ftz,
  input  logic clear_flags,
  input  logic s_valid,
  output logic s_ready,
  input  logic [NUM_LANE*(1+BW_IEEE_EXPONENT+BW_IEEE_MANTISSA)-1:0]                     s_data,
  output logic m_valid,
  input  logic m_ready,
  output logic [NUM_LANE*(BW_FPIR_TYPE+1+BW_FPIR_EXPONENT+BW_FPIR_SIGNIFICAND)-1:0]     m_data,
  output logic nan_seen,
  output logic subnormal_seen
);
  localparam int E       = BW_IEEE_EXPONENT;
  localparam int M       = BW_IEEE_MANTISSA;
  localparam int BW_IEEE = ieee_width(BW_IEEE_EXPONENT, BW_IEEE_MANTISSA);
  localparam int BW_FPIR = fpir_width(BW_FPIR_EXPONENT, BW_FPIR_SIGNIFICAND);
  localparam int BW_LZC  = $clog2(BW_IEEE_MANTISSA + 1);
  localparam int STAGES  = 2;

  logic [STAGES:1] vld_pipe_d, vld_pipe_q;
  logic adv1, adv2, ld1, ld2, fire;

  logic [NUM_LANE-1:0][BW_CLS-1:0]  c_cls;
  logic [NUM_LANE-1:0]              c_sign;
  logic [NUM_LANE-1:0][E-1:0]       c_exp;
  logic [NUM_LANE-1:0][M-1:0]       c_man;
  logic [NUM_LANE-1:0][BW_LZC-1:0]  c_lzc;
  logic [NUM_LANE-1:0][BW_FPIR-1:0] c_fpir;

  logic [NUM_LANE-1:0][BW_CLS-1:0]  s1_cls_d,  s1_cls_q;
  logic [NUM_LANE-1:0]              s1_sign_d, s1_sign_q;
  logic [NUM_LANE-1:0][E-1:0]       s1_exp_d,  s1_exp_q;
  logic [NUM_LANE-1:0][M-1:0]       s1_man_d,  s1_man_q;
  logic [NUM_LANE-1:0][BW_LZC-1:0]  s1_lzc_d,  s1_lzc_q;
  logic                             s1_ftz_d,  s1_ftz_q;

  logic [NUM_LANE-1:0][BW_FPIR-1:0] s2_fpir_d, s2_fpir_q;
  logic [NUM_LANE-1:0]              s2_nan_d,  s2_nan_q;
  logic [NUM_LANE-1:0]              s2_sub_d,  s2_sub_q;

  logic nan_seen_d, nan_seen_q, sub_seen_d, sub_seen_q;

  assign adv2    = ~vld_pipe_q[2] | m_ready;
  assign adv1    = ~vld_pipe_q[1] | adv2;
  assign ld1     = enable & adv1;
  assign ld2     = enable & adv2;
  assign s_ready = rstnn & enable & adv1;
  assign m_valid = rstnn & enable & vld_pipe_q[2];
  assign fire    = m_valid & m_ready;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    ieee2fpir_lane #(
      .BW_IEEE_EXPONENT   (BW_IEEE_EXPONENT),
      .BW_IEEE_MANTISSA   (BW_IEEE_MANTISSA),
      .BW_FPIR_EXPONENT   (BW_FPIR_EXPONENT),
      .BW_FPIR_SIGNIFICAND(BW_FPIR_SIGNIFICAND),
      .BW_LZC             (BW_LZC)
    ) u_lane (
      .ieee_i (s_data[g*BW_IEEE +: BW_IEEE]),
      .cls_o  (c_cls[g]),
      .sign_o (c_sign[g]),
      .exp_o  (c_exp[g]),
      .man_o  (c_man[g]),
      .lzc_o  (c_lzc[g]),
      .cls_i  (s1_cls_q[g]),
      .sign_i (s1_sign_q[g]),
      .exp_i  (s1_exp_q[g]),
      .man_i  (s1_man_q[g]),
      .lzc_i  (s1_lzc_q[g]),
      .ftz_i  (s1_ftz_q),
      .fpir_o (c_fpir[g])
    );
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_cls_d   = s1_cls_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_man_d   = s1_man_q;
    s1_lzc_d   = s1_lzc_q;
    s1_ftz_d   = s1_ftz_q;
    s2_fpir_d  = s2_fpir_q;
    s2_nan_d   = s2_nan_q;
    s2_sub_d   = s2_sub_q;
    if (ld1) begin
      vld_pipe_d[1] = s_valid;
      s1_cls_d      = c_cls;
      s1_sign_d     = c_sign;
      s1_exp_d      = c_exp;
      s1_man_d      = c_man;
      s1_lzc_d      = c_lzc;
      s1_ftz_d      = ftz;
    end
    if (ld2) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      s2_fpir_d     = c_fpir;
      for (int l = 0; l < NUM_LANE; l++) begin
        s2_nan_d[l] = (s1_cls_q[l] == CLS_NAN);
        s2_sub_d[l] = (s1_cls_q[l] == CLS_SUB);
      end
    end
    // A set event on the same cycle as a clear takes priority.
    nan_seen_d = nan_seen_q;
    sub_seen_d = sub_seen_q;
    if (enable & clear_flags) begin
      nan_seen_d = 1'b0;
      sub_seen_d = 1'b0;
    end
    if (fire & |s2_nan_q) nan_seen_d = 1'b1;
    if (fire & |s2_sub_q) sub_seen_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      vld_pipe_q <= '0;
      s1_cls_q   <= '0;
      s1_sign_q  <= '0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_lzc_q   <= '0;
      s1_ftz_q   <= 1'b0;
      s2_fpir_q  <= '0;
      s2_nan_q   <= '0;
      s2_sub_q   <= '0;
      nan_seen_q <= 1'b0;
      sub_seen_q <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_cls_q   <= s1_cls_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_man_q   <= s1_man_d;
      s1_lzc_q   <= s1_lzc_d;
      s1_ftz_q   <= s1_ftz_d;
      s2_fpir_q  <= s2_fpir_d;
      s2_nan_q   <= s2_nan_d;
      s2_sub_q   <= s2_sub_d;
      nan_seen_q <= nan_seen_d;
      sub_seen_q <= sub_seen_d;
    end
  end

  assign m_data         = s2_fpir_q;
  assign nan_seen       = nan_seen_q;
  assign subnormal_seen = sub_seen_q;

endmodule

// File: tb/tb_ieee2fpir_pipe.sv
// Directed bench: single-precision 4-lane DUT plus a half-precision 2-lane DUT.
module tb_ieee2fpir_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstnn, enable, ftz, clear_flags, s_valid, s_ready, m_valid, m_ready;
  logic [127:0] s_data;
  logic [151:0] m_data;
  logic         nan_seen, subnormal_seen;

  logic         h_s_valid, h_s_ready, h_m_valid, h_nan, h_sub;
  logic [31:0]  h_s_data;
  logic [43:0]  h_m_data;

  ieee2fpir_pipe dut (
    .clk(clk), .rstnn(rstnn), .enable(enable), .ftz(ftz), .clear_flags(clear_flags),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .nan_seen(nan_seen), .subnormal_seen(subnormal_seen)
  );

  ieee2fpir_pipe #(.NUM_LANE(2), .BW_IEEE_EXPONENT(5), .BW_IEEE_MANTISSA(10)) dut_h (
    .clk(clk), .rstnn(rstnn), .enable(1'b1), .ftz(1'b0), .clear_flags(1'b0),
    .s_valid(h_s_valid), .s_ready(h_s_ready), .s_data(h_s_data),
    .m_valid(h_m_valid), .m_ready(1'b1), .m_data(h_m_data),
    .nan_seen(h_nan), .subnormal_seen(h_sub)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [151:0] got, input logic [151:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Single-precision FPIR word: {type, sign, exp[9:0], sig[23:0]}
  function automatic logic [37:0] mk(input int t, input int s, input int e, input int sig);
    logic [31:0] tv, sv, ev, gv;
    tv = t; sv = s; ev = e; gv = sig;
    return {tv[2:0], sv[0], ev[9:0], gv[23:0]};
  endfunction

  typedef struct {
    logic [31:0] in;
    logic        fz;
    logic [37:0] exp;
  } vec_t;

  vec_t vt[13];

  task automatic xfer(input logic [127:0] d, input logic fz,
                      output logic [151:0] got, output logic [1:0] lat);
    @(negedge clk); s_data = d; ftz = fz; s_valid = 1'b1;
    @(negedge clk); s_valid = 1'b0; ftz = 1'b0; lat[1] = m_valid;
    @(negedge clk); lat[0] = m_valid; got = m_data;
  endtask

  task automatic run_stream(input int n, input int mr_lo, input int mr_hi,
                            input int en_lo, input int en_hi,
                            output int rdy_lo, output int last_rx);
    int sent, recv, bad_en;
    logic [31:0] v;
    sent = 0; recv = 0; bad_en = 0; rdy_lo = 0; last_rx = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      m_ready = !(cyc >= mr_lo && cyc <= mr_hi);
      enable  = !(cyc >= en_lo && cyc <= en_hi);
      s_valid = (sent < n);
      v = 32'h3F800000 + 32'((sent + 1) << 23);
      s_data = {4{v}};
      #1;
      if (!enable && (s_ready || m_valid)) bad_en++;
      if (enable && s_valid && !s_ready) rdy_lo++;
      if (m_valid && m_ready) begin
        if (recv < n) chk($sformatf("stream_item%0d", recv), m_data, {4{mk(0, 0, recv + 1, 'h800000)}});
        else          chk("stream_extra", 152'(recv), 152'(n));
        recv++;
        last_rx = cyc;
      end
      if (s_valid && s_ready) sent++;
    end
    @(negedge clk); s_valid = 1'b0; m_ready = 1'b1; enable = 1'b1;
    chk("stream_count", 152'(recv), 152'(n));
    chk("stream_disabled_outputs", 152'(bad_en), 152'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [151:0] got;
    logic [1:0]   lat;
    int lo, last, mv_cnt;

    vt[0]  = '{32'h3F800000, 1'b0, mk(0, 0, 0,    'h800000)};
    vt[1]  = '{32'hC0000000, 1'b0, mk(0, 1, 1,    'h800000)};
    vt[2]  = '{32'h00800000, 1'b0, mk(0, 0, -126, 'h800000)};
    vt[3]  = '{32'h00000001, 1'b0, mk(0, 0, -149, 'h800000)};
    vt[4]  = '{32'h00000001, 1'b1, mk(2, 0, 0,    0)};
    vt[5]  = '{32'h80400000, 1'b0, mk(0, 1, -127, 'h800000)};
    vt[6]  = '{32'h80000001, 1'b1, mk(3, 1, 0,    0)};
    vt[7]  = '{32'h00300000, 1'b0, mk(0, 0, -128, 'hC00000)};
    vt[8]  = '{32'h7F7FFFFF, 1'b0, mk(0, 0, 127,  'hFFFFFF)};
    vt[9]  = '{32'h3FC00000, 1'b0, mk(0, 0, 0,    'hC00000)};
    vt[10] = '{32'hFFC00001, 1'b0, mk(1, 1, 0,    0)};
    vt[11] = '{32'h80000000, 1'b0, mk(3, 1, 0,    0)};
    vt[12] = '{32'h00000000, 1'b1, mk(2, 0, 0,    0)};

    rstnn = 1'b0; enable = 1'b1; ftz = 1'b0; clear_flags = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    h_s_valid = 1'b0; h_s_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_flags", {nan_seen, subnormal_seen}, 0);
    rstnn = 1'b1;
    #1 chk("post_rst_s_ready", s_ready, 1);

    // Single-lane vector table
    for (int i = 0; i < 13; i++) begin
      xfer({96'h0, vt[i].in}, vt[i].fz, got, lat);
      chk($sformatf("lat_v%0d", i), lat, 2'b01);
      chk($sformatf("data_v%0d", i), got[37:0], vt[i].exp);
      if (i == 0) chk("idle_lanes_pzero", got[151:38], {3{mk(2, 0, 0, 0)}});
      if (i == 2) begin
        @(negedge clk);
        chk("flags_after_normals", {nan_seen, subnormal_seen}, 0);
      end
    end
    @(negedge clk);
    chk("flags_after_table", {nan_seen, subnormal_seen}, 2'b11);

    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    chk("flags_cleared", {nan_seen, subnormal_seen}, 0);

    // Special lanes; clear asserted on the same cycle as the NaN transfer
    xfer({32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000}, 1'b0, got, lat);
    chk("special_lanes", got, {mk(3, 1, 0, 0), mk(4, 0, 0, 0), mk(5, 1, 0, 0), mk(1, 0, 0, 0)});
    clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    chk("set_wins_over_clear", {nan_seen, subnormal_seen}, 2'b10);

    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    xfer({96'h0, 32'h00000001}, 1'b1, got, lat);
    @(negedge clk);
    chk("ftz_sets_subnormal_seen", {nan_seen, subnormal_seen}, 2'b01);

    // Backpressure: m_ready low on cycles 3..7
    run_stream(6, 3, 7, 100, -1, lo, last);
    chk("bp_s_ready_low_cycles", 152'(lo), 152'(5));
    chk("bp_last_rx_cycle", 152'(last), 152'(12));

    // enable low on cycles 2..4
    run_stream(4, 100, -1, 2, 4, lo, last);
    chk("en_s_ready_low_cycles", 152'(lo), 152'(0));
    chk("en_last_rx_cycle", 152'(last), 152'(8));

    // Reset with two items in flight
    xfer({4{32'h7FC00000}}, 1'b0, got, lat);
    @(negedge clk);
    chk("nan_before_reset", nan_seen, 1);
    s_valid = 1'b1; s_data = {4{32'h3F800000}};
    #1 chk("inflight_accept", s_ready, 1);
    @(negedge clk); s_data = {4{32'h40000000}};
    @(negedge clk); s_valid = 1'b0; rstnn = 1'b0;
    #1 chk("mid_rst_m_valid", {m_valid, s_ready}, 0);
    @(negedge clk); rstnn = 1'b1;
    #1;
    chk("after_rst_state", {m_valid, nan_seen, subnormal_seen}, 0);
    chk("after_rst_s_ready", s_ready, 1);
    chk("after_rst_m_data", m_data, 0);
    mv_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_valid) mv_cnt++;
    end
    chk("no_stale_outputs", 152'(mv_cnt), 0);

    // Half precision, two lanes
    @(negedge clk);
    chk("half_s_ready", h_s_ready, 1);
    h_s_valid = 1'b1; h_s_data = {16'h0001, 16'h0400};
    @(negedge clk); h_s_valid = 1'b0;
    @(negedge clk);
    chk("half_m_valid", h_m_valid, 1);
    chk("half_data", h_m_data, {3'd0, 1'b0, 7'h68, 11'h400, 3'd0, 1'b0, 7'h72, 11'h400});
    @(negedge clk);
    chk("half_flags", {h_nan, h_sub}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
